sramlike_axi_bridge: RTL and testbench
======================================

Name: sramlike_axi_bridge

Overview:
Converts the core's two SRAM-like request ports (inst, data) into one AXI4 master toward the system cache slave port. It arbitrates both ports onto a single read channel, data port first, and issues data-port writes on the AW/W/B channels. It sits between the core and the system cache. It allows at most one outstanding read and one outstanding write, and returns responses in order per port.

Parameters:
DATA_PRIO, 1, 1 = data port wins the read channel when inst and data request in the same cycle; 0 = inst wins.
CACHED_ATTR, 4'b1111, ar/awcache value for cached requests (uncached requests always use 4'b0000).

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
inst_req / inst_size / inst_addr / inst_uncached  in  1/2/32/1  inst-port read request (port is read-only)
inst_addr_ok / inst_data_ok  out  1/1  request accepted / read data valid
inst_rdata  out  32  read data, valid with inst_data_ok
data_req / data_wr / data_size / data_addr / data_wdata / data_uncached  in  1/1/2/32/32/1  data-port request
data_addr_ok / data_data_ok  out  1/1  request accepted / response complete
data_rdata  out  32  read data, valid with data_data_ok
arid / araddr / arlen / arsize / arvalid  out  1/32/8/3/1  AR channel
arready  in  1  AR ready
rid / rdata / rresp / rlast / rvalid  in  1/32/2/1/1  R channel
rready  out  1  R ready
awid / awaddr / awlen / awsize / awvalid  out  1/32/8/3/1  AW channel
awready  in  1  AW ready
wdata / wstrb / wlast / wvalid  out  32/4/1/1  W channel
wready  in  1  W ready
bid / bresp / bvalid  in  1/2/1  B channel
bready  out  1  B ready
arburst, awburst  out  2  constant 2'b01; arlock, awlock  out  1  constant 0; arprot, awprot  out  3  constant 0; arqos, awqos  out  4  constant 0
arcache, awcache  out  4  CACHED_ATTR, or 4'b0000 when the request is uncached

Behaviour:
- Reset (aresetn low, async): both FSMs go to IDLE. All valid and ready outputs, addr_ok, data_ok and rdata are 0. Reset mid-transaction drops the transaction; no response is produced.
- Read FSM: R_IDLE -> R_AR on accepting a read. R_AR -> R_R on arvalid&arready. R_R -> R_IDLE on rvalid&rready&rlast.
- Write FSM: W_IDLE -> W_AW on accepting a write. awvalid and wvalid rise together. Each drops independently on its own handshake, in either order.
- W_AW -> W_B once both the AW and W handshakes have completed. W_B -> W_IDLE on bvalid&bready.
- addr_ok is combinational in the cycle of acceptance (req & condition). Address, size, wdata and uncached are registered on acceptance.
- Data port accepts only when it has no outstanding transaction. A data read also needs R_IDLE. A data write also needs W_IDLE.
- Inst port accepts when it has no outstanding read, R_IDLE holds, and it does not lose arbitration.
- Inst RAW hazard: an inst read is stalled while a write is outstanding and inst_addr[31:2] == the pending write address[31:2].
- Beats: arlen = awlen = 0; wlast = 1. arid = 0 for inst, 1 for data; awid = 1.
- Size encoding: ar/awsize = {1'b0, size}. size 2'b11 is treated as 2'b10.
- Write strobes: wstrb = 4'b0001 << addr[1:0] (size 0), 4'b0011 << {addr[1],1'b0} (size 1), 4'b1111 (size 2). wdata is passed through unshifted.
- rready = 1 in R_R; bready = 1 in W_B.
- Read response: on the final R beat, the owner's data_ok pulses for exactly one cycle and rdata is registered. Ownership comes from the stored owner flag, not rid.
- Write response: data_data_ok pulses for one cycle on the B handshake. rresp and bresp are ignored.
- Simultaneous events: inst_data_ok and data_data_ok may pulse in the same cycle. A new request may be accepted in the same cycle its port's data_ok pulses.

Decomposition:
- Shared package axi_pkg holds FSM state enums, BURST_INCR, the ID constants (ID_INST=0, ID_DATA=1) and a wstrb-generation function.
- One sub-module, axi_wstrb_gen (size + addr -> wstrb), which is combinational and reused by the cache path.

Test Plan:
- Inst read 0xBFC00000 with arready/rvalid delayed 3 cycles -> arid=0, arlen=0, arsize=2; inst_data_ok pulses 1 cycle with rdata.
- Inst and data reads in the same cycle with DATA_PRIO=1 -> data_addr_ok=1 and inst_addr_ok=0; inst is issued only after the data R beat.
- Data byte write at addr 0x...3, wdata 0xAABBCCDD, with wready before awready -> wstrb=4'b1000; data_data_ok only after bvalid.
- Data write pending at 0x1000 plus inst read at 0x1002 -> inst_addr_ok held 0 until B completes; a read at 0x2000 is accepted.
- Data req with uncached=1 -> arcache=4'b0000; with uncached=0 -> arcache=4'b1111.
- aresetn dropped during R_R -> all valid/ready outputs 0 immediately; no data_ok after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM-like bridge and the cache path:
// FSM state encodings, fixed AXI field values and write-strobe generation.
package axi_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_B    = 2'd2
    } w_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic       ID_INST    = 1'b0;
    localparam logic       ID_DATA    = 1'b1;

    // The SRAM-like size code 2'b11 has no wider meaning here; fold it to a word.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? 2'b10 : size;
    endfunction

    function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (norm_size(size))
            2'b00:   strb = 4'b0001 << addr_lo;
            2'b01:   strb = 4'b0011 << {addr_lo[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sramlike_axi_bridge_if.sv
// AXI4 master-side bundle between the bridge and the system cache slave port.
interface sramlike_axi_bridge_if;

    logic        arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic        arvalid;
    logic        arready;

    logic        rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic        awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic        bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe generation from an SRAM-like size code and the low address bits.
module axi_wstrb_gen
    import axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = wstrb_of(size, addr_lo);
    end

endmodule

// File: rtl/sramlike_axi_bridge.sv
// Bridges the core's SRAM-like inst/data ports onto one AXI4 master with at most
// one outstanding read and one outstanding write.
module sramlike_axi_bridge
    import axi_pkg::*;
#(
    parameter logic       DATA_PRIO   = 1'b1,
    parameter logic [3:0] CACHED_ATTR = 4'b1111
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic        inst_uncached,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_uncached,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    sramlike_axi_bridge_if.master axi
);

    r_state_e    r_state;
    logic        r_owner;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_uncached;

    w_state_e    w_state;
    logic        aw_pend;
    logic        w_pend;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [1:0]  w_size;
    logic        w_uncached;
    logic [3:0]  w_strb;

    logic        inst_ok_q;
    logic        data_ok_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;

    logic r_idle, w_idle, data_free, raw_hazard;
    logic inst_cand, data_rd_cand;
    logic inst_go, data_rd_go, data_wr_go;
    logic r_fire, b_fire;
    logic unused_resp;

    // Acceptance is gated by aresetn so nothing reports addr_ok while held in reset.
    always_comb begin
        r_idle       = (r_state == R_IDLE);
        w_idle       = (w_state == W_IDLE);
        data_free    = w_idle && !(!r_idle && (r_owner == ID_DATA));
        raw_hazard   = !w_idle && (inst_addr[31:2] == w_addr[31:2]);
        inst_cand    = aresetn && inst_req && r_idle && !raw_hazard;
        data_rd_cand = aresetn && data_req && !data_wr && data_free && r_idle;
        data_wr_go   = aresetn && data_req && data_wr && data_free;
        inst_go      = inst_cand && !(DATA_PRIO && data_rd_cand);
        data_rd_go   = data_rd_cand && !(!DATA_PRIO && inst_cand);
        r_fire       = (r_state == R_R) && axi.rvalid && axi.rlast;
        b_fire       = (w_state == W_B) && axi.bvalid;
    end

    assign inst_addr_ok = inst_go;
    assign data_addr_ok = data_rd_go || data_wr_go;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= R_IDLE;
            r_owner    <= ID_INST;
            r_addr     <= '0;
            r_size     <= '0;
            r_uncached <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (inst_go) begin
                        r_state    <= R_AR;
                        r_owner    <= ID_INST;
                        r_addr     <= inst_addr;
                        r_size     <= norm_size(inst_size);
                        r_uncached <= inst_uncached;
                    end else if (data_rd_go) begin
                        r_state    <= R_AR;
                        r_owner    <= ID_DATA;
                        r_addr     <= data_addr;
                        r_size     <= norm_size(data_size);
                        r_uncached <= data_uncached;
                    end
                end
                R_AR: begin
                    if (axi.arready) begin
                        r_state <= R_R;
                    end
                end
                R_R: begin
                    if (r_fire) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // AW and W retire independently; the FSM leaves W_AW once neither is still pending.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state    <= W_IDLE;
            aw_pend    <= 1'b0;
            w_pend     <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            w_size     <= '0;
            w_uncached <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (data_wr_go) begin
                        w_state    <= W_AW;
                        aw_pend    <= 1'b1;
                        w_pend     <= 1'b1;
                        w_addr     <= data_addr;
                        w_data     <= data_wdata;
                        w_size     <= norm_size(data_size);
                        w_uncached <= data_uncached;
                    end
                end
                W_AW: begin
                    if (aw_pend && axi.awready) begin
                        aw_pend <= 1'b0;
                    end
                    if (w_pend && axi.wready) begin
                        w_pend <= 1'b0;
                    end
                    if ((!aw_pend || axi.awready) && (!w_pend || axi.wready)) begin
                        w_state <= W_B;
                    end
                end
                W_B: begin
                    if (b_fire) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            inst_ok_q <= r_fire && (r_owner == ID_INST);
            data_ok_q <= (r_fire && (r_owner == ID_DATA)) || b_fire;
            if (r_fire && (r_owner == ID_INST)) begin
                inst_rdata_q <= axi.rdata;
            end
            if (r_fire && (r_owner == ID_DATA)) begin
                data_rdata_q <= axi.rdata;
            end
        end
    end

    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;

    axi_wstrb_gen u_wstrb (
        .size    (w_size),
        .addr_lo (w_addr[1:0]),
        .wstrb   (w_strb)
    );

    assign axi.arid    = r_owner;
    assign axi.araddr  = r_addr;
    assign axi.arlen   = '0;
    assign axi.arsize  = {1'b0, r_size};
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = r_uncached ? 4'b0000 : CACHED_ATTR;
    assign axi.arprot  = '0;
    assign axi.arqos   = '0;
    assign axi.arvalid = (r_state == R_AR);
    assign axi.rready  = (r_state == R_R);

    assign axi.awid    = ID_DATA;
    assign axi.awaddr  = w_addr;
    assign axi.awlen   = '0;
    assign axi.awsize  = {1'b0, w_size};
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = w_uncached ? 4'b0000 : CACHED_ATTR;
    assign axi.awprot  = '0;
    assign axi.awqos   = '0;
    assign axi.awvalid = aw_pend;

    assign axi.wdata   = w_data;
    assign axi.wstrb   = w_strb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = w_pend;
    assign axi.bready  = (w_state == W_B);

    // Response IDs and status are not used: ownership comes from r_owner.
    assign unused_resp = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Scoreboard bench for sramlike_axi_bridge: directed requests push expected AXI
// beats and port responses; a negedge monitor pops and compares them.
module tb_sramlike_axi_bridge;

    typedef struct packed {
        logic        id;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  cache;
    } addr_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_exp_t;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] rdata;
    } dresp_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req, inst_uncached, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_uncached, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;

    sramlike_axi_bridge_if axi ();

    sramlike_axi_bridge #(
        .DATA_PRIO   (1'b1),
        .CACHED_ATTR (4'b1111)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .inst_req      (inst_req),
        .inst_size     (inst_size),
        .inst_addr     (inst_addr),
        .inst_uncached (inst_uncached),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_uncached (data_uncached),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .axi           (axi)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    int r_hs_cnt = 0, b_hs_cnt = 0, inst_ok_cnt = 0;
    logic aw_seen = 1'b0, w_seen = 1'b0, b_seen = 1'b0;

    addr_exp_t   ar_q[$], aw_q[$];
    w_exp_t      w_q[$];
    logic [31:0] inst_q[$], rdat_q[$];
    dresp_t      data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // ---------------- AXI slave model ----------------
    initial begin
        logic sid;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
        axi.rdata = '0; axi.rid = 1'b0; axi.rresp = '0;
        forever begin
            @(posedge aclk); #1;
            if (axi.arvalid) begin
                repeat (ar_dly) begin @(posedge aclk); #1; end
                axi.arready = 1'b1;
                sid = axi.arid;
                @(posedge aclk); #1;
                axi.arready = 1'b0;
                repeat (r_dly) begin @(posedge aclk); #1; end
                axi.rvalid = 1'b1;
                axi.rlast  = 1'b1;
                axi.rid    = sid;
                axi.rdata  = (rdat_q.size() != 0) ? rdat_q.pop_front() : 32'hDEAD_BEEF;
                @(posedge aclk); #1;
                axi.rvalid = 1'b0;
                axi.rlast  = 1'b0;
            end
        end
    end

    initial begin
        axi.awready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (axi.awvalid) begin
                repeat (aw_dly) begin @(posedge aclk); #1; end
                axi.awready = 1'b1;
                @(posedge aclk); #1;
                axi.awready = 1'b0;
                aw_seen = 1'b1;
            end
        end
    end

    initial begin
        axi.wready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            if (axi.wvalid) begin
                repeat (w_dly) begin @(posedge aclk); #1; end
                axi.wready = 1'b1;
                @(posedge aclk); #1;
                axi.wready = 1'b0;
                w_seen = 1'b1;
            end
        end
    end

    initial begin
        axi.bvalid = 1'b0; axi.bid = 1'b0; axi.bresp = '0;
        forever begin
            @(posedge aclk); #1;
            if (aw_seen && w_seen) begin
                aw_seen = 1'b0;
                w_seen  = 1'b0;
                repeat (b_dly) begin @(posedge aclk); #1; end
                axi.bvalid = 1'b1;
                axi.bid    = 1'b1;
                @(posedge aclk); #1;
                axi.bvalid = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    addr_exp_t ae;
    w_exp_t    we;
    dresp_t    de;
    logic [31:0] ie;

    always @(negedge aclk) begin
        if (aresetn) begin
            if (axi.arvalid && axi.arready) begin
                if (ar_q.size() == 0) fail_now("ar_unexpected");
                else begin
                    ae = ar_q.pop_front();
                    check("arid", axi.arid, ae.id);
                    check("araddr", axi.araddr, ae.addr);
                    check("arsize", axi.arsize, ae.size);
                    check("arcache", axi.arcache, ae.cache);
                    check("arlen", axi.arlen, 0);
                end
            end
            if (axi.awvalid && axi.awready) begin
                if (aw_q.size() == 0) fail_now("aw_unexpected");
                else begin
                    ae = aw_q.pop_front();
                    check("awid", axi.awid, ae.id);
                    check("awaddr", axi.awaddr, ae.addr);
                    check("awsize", axi.awsize, ae.size);
                    check("awcache", axi.awcache, ae.cache);
                    check("awlen", axi.awlen, 0);
                end
            end
            if (axi.wvalid && axi.wready) begin
                if (w_q.size() == 0) fail_now("w_unexpected");
                else begin
                    we = w_q.pop_front();
                    check("wdata", axi.wdata, we.data);
                    check("wstrb", axi.wstrb, we.strb);
                    check("wlast", axi.wlast, 1);
                end
            end
            if (axi.rvalid && axi.rready && axi.rlast) r_hs_cnt++;
            if (axi.bvalid && axi.bready) begin
                b_hs_cnt++;
                b_seen = 1'b1;
            end
            if (inst_data_ok) begin
                inst_ok_cnt++;
                if (inst_q.size() == 0) fail_now("inst_data_ok_unexpected");
                else begin
                    ie = inst_q.pop_front();
                    check("inst_rdata", inst_rdata, ie);
                end
            end
            if (data_data_ok) begin
                if (data_q.size() == 0) fail_now("data_data_ok_unexpected");
                else begin
                    de = data_q.pop_front();
                    if (de.is_wr) begin
                        check("wr_ok_after_b", b_seen, 1);
                        b_seen = 1'b0;
                    end else begin
                        check("data_rdata", data_rdata, de.rdata);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic inst_read(input logic [31:0] addr, input logic [1:0] size, input logic unc,
                             input logic [31:0] rd, input bit want_resp,
                             input logic [2:0] exp_size, input logic [3:0] exp_cache,
                             output int waited);
        ar_q.push_back('{id: 1'b0, addr: addr, size: exp_size, cache: exp_cache});
        rdat_q.push_back(rd);
        if (want_resp) inst_q.push_back(rd);
        @(posedge aclk); #1;
        inst_req = 1'b1; inst_addr = addr; inst_size = size; inst_uncached = unc;
        waited = 0;
        forever begin
            @(negedge aclk);
            if (inst_addr_ok) break;
            waited++;
            if (waited > 100) begin
                fail_now("inst_accept_timeout");
                break;
            end
        end
        @(posedge aclk); #1;
        inst_req = 1'b0;
    endtask

    task automatic data_access(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                               input logic unc, input logic [31:0] wd_or_rd,
                               input logic [2:0] exp_size, input logic [3:0] exp_cache,
                               input logic [3:0] exp_strb);
        int waited;
        if (wr) begin
            aw_q.push_back('{id: 1'b1, addr: addr, size: exp_size, cache: exp_cache});
            w_q.push_back('{data: wd_or_rd, strb: exp_strb});
            data_q.push_back('{is_wr: 1'b1, rdata: 32'h0});
        end else begin
            ar_q.push_back('{id: 1'b1, addr: addr, size: exp_size, cache: exp_cache});
            rdat_q.push_back(wd_or_rd);
            data_q.push_back('{is_wr: 1'b0, rdata: wd_or_rd});
        end
        @(posedge aclk); #1;
        data_req = 1'b1; data_wr = wr; data_addr = addr; data_size = size;
        data_uncached = unc; data_wdata = wr ? wd_or_rd : 32'h0;
        waited = 0;
        forever begin
            @(negedge aclk);
            if (data_addr_ok) break;
            waited++;
            if (waited > 100) begin
                fail_now("data_accept_timeout");
                break;
            end
        end
        @(posedge aclk); #1;
        data_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (ar_q.size() + aw_q.size() + w_q.size() + inst_q.size() + data_q.size() != 0) begin
            @(negedge aclk);
            n++;
            if (n > 300) begin
                fail_now("drain_timeout");
                break;
            end
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    int w0, r0, b0, ok0, n;

    initial begin
        aresetn = 1'b0;
        inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h0; inst_uncached = 1'b0;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h40;
        data_wdata = 32'h0; data_uncached = 1'b0;

        // reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_inst_addr_ok", inst_addr_ok, 0);
        check("rst_data_addr_ok", data_addr_ok, 0);
        check("rst_inst_data_ok", inst_data_ok, 0);
        check("rst_data_data_ok", data_data_ok, 0);
        check("rst_inst_rdata", inst_rdata, 0);
        check("rst_data_rdata", data_rdata, 0);
        check("arburst", axi.arburst, 2'b01);
        check("awburst", axi.awburst, 2'b01);
        inst_req = 1'b0; data_req = 1'b0;
        @(posedge aclk); #3;
        aresetn = 1'b1;

        // inst read with delayed slave
        ar_dly = 3; r_dly = 3;
        inst_read(32'hBFC0_0000, 2'd2, 1'b0, 32'h1234_5678, 1'b1, 3'd2, 4'b1111, n);
        drain();

        // simultaneous inst/data read: data wins
        ar_dly = 0; r_dly = 2;
        ar_q.push_back('{id: 1'b1, addr: 32'h0000_0200, size: 3'd2, cache: 4'b1111});
        ar_q.push_back('{id: 1'b0, addr: 32'h0000_0100, size: 3'd2, cache: 4'b1111});
        rdat_q.push_back(32'hD0D0_0200);
        rdat_q.push_back(32'h1010_0100);
        data_q.push_back('{is_wr: 1'b0, rdata: 32'hD0D0_0200});
        inst_q.push_back(32'h1010_0100);
        @(posedge aclk); #1;
        inst_req = 1'b1; inst_addr = 32'h0000_0100; inst_size = 2'd2; inst_uncached = 1'b0;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0200; data_size = 2'd2; data_uncached = 1'b0;
        @(negedge aclk);
        check("prio_data_addr_ok", data_addr_ok, 1);
        check("prio_inst_addr_ok", inst_addr_ok, 0);
        r0 = r_hs_cnt;
        @(posedge aclk); #1;
        data_req = 1'b0;
        n = 0;
        forever begin
            @(negedge aclk);
            if (inst_addr_ok) break;
            n++;
            if (n > 100) begin fail_now("prio_inst_timeout"); break; end
        end
        check("inst_after_data_r", r_hs_cnt, r0 + 1);
        @(posedge aclk); #1;
        inst_req = 1'b0;
        drain();

        // byte write at offset 3, W before AW
        aw_dly = 3; w_dly = 0; b_dly = 2;
        data_access(1'b1, 32'h0000_1003, 2'd0, 1'b0, 32'hAABB_CCDD, 3'd0, 4'b1111, 4'b1000);
        drain();
        // uncached halfword write at offset 2, AW before W
        aw_dly = 0; w_dly = 2; b_dly = 0;
        data_access(1'b1, 32'h0000_2002, 2'd1, 1'b1, 32'h5566_7788, 3'd1, 4'b0000, 4'b1100);
        drain();

        // RAW hazard against a pending write
        aw_dly = 0; w_dly = 0; b_dly = 15; r_dly = 0;
        b0 = b_hs_cnt;
        data_access(1'b1, 32'h0000_1000, 2'd2, 1'b0, 32'h1111_2222, 3'd2, 4'b1111, 4'b1111);
        inst_read(32'h0000_2000, 2'd2, 1'b0, 32'h2000_AAAA, 1'b1, 3'd2, 4'b1111, n);
        check("raw_other_addr_no_wait", n, 0);
        n = 0;
        while (inst_q.size() != 0 && n < 100) begin @(negedge aclk); n++; end
        check("raw_write_still_pending", b_hs_cnt, b0);
        inst_read(32'h0000_1002, 2'd2, 1'b0, 32'h3333_4444, 1'b1, 3'd2, 4'b1111, n);
        check("raw_accept_after_b", b_hs_cnt, b0 + 1);
        check("raw_was_stalled", (n > 0) ? 1 : 0, 1);
        drain();

        // cacheability and size folding
        b_dly = 0;
        data_access(1'b0, 32'h0000_3000, 2'd2, 1'b1, 32'h0BAD_F00D, 3'd2, 4'b0000, 4'b0000);
        data_access(1'b0, 32'h0000_3004, 2'd3, 1'b0, 32'hCAFE_0004, 3'd2, 4'b1111, 4'b0000);
        data_access(1'b0, 32'h0000_3001, 2'd0, 1'b0, 32'h0000_00A5, 3'd0, 4'b1111, 4'b0000);
        inst_read(32'h0000_3006, 2'd1, 1'b1, 32'h6666_0006, 1'b1, 3'd1, 4'b0000, n);
        drain();

        // reset during R_R drops the transaction
        ar_dly = 0; r_dly = 20;
        ok0 = inst_ok_cnt;
        inst_read(32'h0000_4000, 2'd2, 1'b0, 32'h7777_8888, 1'b0, 3'd2, 4'b1111, n);
        n = 0;
        forever begin
            @(negedge aclk);
            if (axi.rready) break;
            n++;
            if (n > 100) begin fail_now("rr_timeout"); break; end
        end
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1;
        check("mid_rst_arvalid", axi.arvalid, 0);
        check("mid_rst_rready", axi.rready, 0);
        check("mid_rst_awvalid", axi.awvalid, 0);
        check("mid_rst_wvalid", axi.wvalid, 0);
        check("mid_rst_bready", axi.bready, 0);
        check("mid_rst_inst_rdata", inst_rdata, 0);
        check("mid_rst_data_rdata", data_rdata, 0);
        @(posedge aclk); #3;
        aresetn = 1'b1;
        repeat (30) @(posedge aclk);
        #1;
        check("no_resp_after_reset", inst_ok_cnt, ok0);

        check("left_ar", ar_q.size(), 0);
        check("left_aw", aw_q.size(), 0);
        check("left_w", w_q.size(), 0);
        check("left_inst", inst_q.size(), 0);
        check("left_data", data_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
